// File: rtl/serial_subtractor_24.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_24
// Description : Bit-serial two's-complement subtractor, DIFF = A - B - BorrowIn.
//               One full-subtractor cell and a registered borrow process one
//               bit per clock, LSB first, over WIDTH cycles. Start/Busy/Done
//               handshake; produces borrow, signed-overflow and zero flags.
// Ports       : clk        - sole clock, rising edge
//               rst        - synchronous active-high reset
//               start      - request, sampled in IDLE or DONE
//               a, b       - minuend / subtrahend, captured on accept
//               borrow_in  - initial borrow, captured on accept
//               busy       - high while bits are being processed
//               done       - one-cycle pulse when results become valid
//               diff       - A - B - BorrowIn modulo 2^WIDTH
//               bout       - final borrow (unsigned A < B + BorrowIn)
//               ovf        - signed overflow
//               zero       - diff == 0
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_24 #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int                 CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_ash;
    logic [WIDTH-1:0]   r_bsh;
    // Holds the WIDTH-1 most recent difference bits; the newest bit is
    // combined with it on the final step to form the full result.
    logic [WIDTH-2:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic               w_a;
    logic               w_b;
    logic               w_w;
    logic               w_d;
    logic               w_borrow_nxt;
    logic [WIDTH-1:0]   w_full;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

    // Single full-subtractor cell
    assign w_a          = r_ash[0];
    assign w_b          = r_bsh[0];
    assign w_w          = r_borrow;
    assign w_d          = w_a ^ w_b ^ w_w;
    assign w_borrow_nxt = (~w_a & w_b) | (~w_a & w_w) | (w_b & w_w);
    assign w_full       = {w_d, r_res};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ash    <= '0;
            r_bsh    <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_ash    <= a;
            r_bsh    <= b;
            r_borrow <= borrow_in;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_ash    <= r_ash >> 1;
            r_bsh    <= r_bsh >> 1;
            r_res    <= w_full[WIDTH-1:1];
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                // On the last step the cell inputs are the captured sign
                // bits, so overflow needs no separate copy of A/B.
                r_diff <= w_full;
                r_bout <= w_borrow_nxt;
                r_ovf  <= (w_a != w_b) && (w_d != w_a);
                r_zero <= (w_full == '0);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_24.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor_24
// Description : Directed and reference-model bench for serial_subtractor_24.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_24;

    localparam int WIDTH = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor_24 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done. Reports latency
    // from the accept edge, number of busy cycles and handshake anomalies.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tbin, output int lat, output int nbusy,
                         output bit both);
        a = ta; b = tb; borrow_in = tbin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; nbusy = busy ? 1 : 0; both = busy && done;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) nbusy++;
            if (busy && done) both = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_vec++;
        if ({busy, done, diff, bout, ovf, zero} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, want all 0",
                     busy, done, diff, bout, ovf, zero);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [5] = '{24'h000005, 24'h000000, 24'h000010, 24'h800000, 24'h5A5A5A};
        logic [WIDTH-1:0] vb [5] = '{24'h000003, 24'h000001, 24'h000010, 24'h000001, 24'h5A5A5A};
        logic             vw [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [WIDTH-1:0] ed [5] = '{24'h000002, 24'hFFFFFF, 24'hFFFFFF, 24'h7FFFFF, 24'h000000};
        logic             eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic             eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic             ez [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat, nbusy;
        bit both;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vw[i], lat, nbusy, both);
            n_vec++;
            if (lat !== WIDTH + 1 || nbusy !== WIDTH || both) begin
                n_err++;
                $display("FAIL timing[%0d]: got latency=%0d busy_cycles=%0d overlap=%0b, want %0d/%0d/0",
                         i, lat, nbusy, both, WIDTH + 1, WIDTH);
            end
            n_vec++;
            if ({diff, bout, ovf, zero} !== {ed[i], eb[i], eo[i], ez[i]}) begin
                n_err++;
                $display("FAIL result[%0d]: got diff=%h bout=%b ovf=%b zero=%b, want diff=%h bout=%b ovf=%b zero=%b",
                         i, diff, bout, ovf, zero, ed[i], eb[i], eo[i], ez[i]);
            end
            tick();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || diff !== ed[i]) begin
                n_err++;
                $display("FAIL done_pulse[%0d]: got done=%b busy=%b diff=%h, want 0/0/%h",
                         i, done, busy, diff, ed[i]);
            end
        end
    endtask

    task automatic test_start_in_run();
        int lat;
        a = 24'h000005; b = 24'h000003; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (5) begin tick(); lat++; end
        a = 24'h000100; b = 24'h000001; borrow_in = 1'b1; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        while (!done && lat < 100) begin tick(); lat++; end
        n_vec++;
        if (lat !== WIDTH + 1 || diff !== 24'h000002) begin
            n_err++;
            $display("FAIL start_in_run: got latency=%0d diff=%h, want %0d diff=000002",
                     lat, diff, WIDTH + 1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, nbusy;
        bit both, hold_ok;
        do_op(24'h000009, 24'h000004, 1'b0, lat, nbusy, both);
        n_vec++;
        if (done !== 1'b1 || diff !== 24'h000005) begin
            n_err++;
            $display("FAIL b2b_first: got done=%b diff=%h, want 1 diff=000005", done, diff);
        end
        // Start asserted during the DONE cycle
        a = 24'h000100; b = 24'h000001; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy, done);
        end
        lat = 1; hold_ok = 1;
        while (!done && lat < 100) begin
            if (diff !== 24'h000005) hold_ok = 0;
            tick(); lat++;
        end
        n_vec++;
        if (!hold_ok) begin
            n_err++;
            $display("FAIL b2b_hold: diff changed during second run, want 000005 throughout");
        end
        n_vec++;
        if (lat !== WIDTH + 1 || diff !== 24'h0000FF) begin
            n_err++;
            $display("FAIL b2b_second: got latency=%0d diff=%h, want %0d diff=0000FF",
                     lat, diff, WIDTH + 1);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, nbusy;
        bit both, saw_done;
        // Leave non-zero results so the reset clearing is observable
        do_op(24'h800000, 24'h000001, 1'b0, lat, nbusy, both);
        tick();
        a = 24'h123456; b = 24'h000001; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({busy, done, diff, bout, ovf, zero} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, want all 0",
                     busy, done, diff, bout, ovf, zero);
        end
        saw_done = 0;
        repeat (40) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL reset_no_done: got activity after abort, want idle");
        end
        do_op(24'h000100, 24'h000080, 1'b1, lat, nbusy, both);
        n_vec++;
        if (lat !== WIDTH + 1 || diff !== 24'h00007F || bout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_recover: got latency=%0d diff=%h bout=%b, want %0d diff=00007F bout=0",
                     lat, diff, bout, WIDTH + 1);
        end
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) begin
            n_err++;
            $display("FAIL reset_over_start: got busy=%b done=%b diff=%h, want 0/0/000000",
                     busy, done, diff);
        end
    endtask

    task automatic test_random();
        int lat, nbusy;
        bit both;
        logic [WIDTH-1:0] ra, rb, ed;
        logic             rw, eb, eo, ez;
        logic [WIDTH:0]   full;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rw = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            full = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rw};
            ed = full[WIDTH-1:0];
            eb = full[WIDTH];
            eo = (ra[WIDTH-1] != rb[WIDTH-1]) && (ed[WIDTH-1] != ra[WIDTH-1]);
            ez = (ed == '0);
            do_op(ra, rb, rw, lat, nbusy, both);
            n_vec++;
            if (lat !== WIDTH + 1 || {diff, bout, ovf, zero} !== {ed, eb, eo, ez}) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h bin=%b: got lat=%0d diff=%h bout=%b ovf=%b zero=%b, want lat=%0d diff=%h bout=%b ovf=%b zero=%b",
                         i, ra, rb, rw, lat, diff, bout, ovf, zero, WIDTH + 1, ed, eb, eo, ez);
            end
            // Alternate between returning to IDLE and going straight from DONE
            if (i % 2 == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
